// File: rtl/serial_maxmin.sv
// Bit-serial MSB-first N-channel max/min selector with stall, restart and
// winner/tie reporting. One bit per channel is consumed per accepted cycle.
module serial_maxmin #(
  parameter  int CHANNELS = 4,
  parameter  int WORD     = 8,
  localparam int IDXW     = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                start,
  input  logic                mode,
  input  logic [CHANNELS-1:0] din,
  output logic                out,
  output logic                out_valid,
  output logic                done,
  output logic [IDXW-1:0]     winner,
  output logic                tie,
  output logic                busy
);

  localparam int            CW   = $clog2(WORD);
  localparam logic [CW-1:0] LAST = CW'(WORD - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [CHANNELS-1:0]   alive_q, alive_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic                  out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  done_q, done_d;
  logic [IDXW-1:0]       winner_q, winner_d;
  logic                  tie_q, tie_d;

  logic                  accept;
  logic                  eff_mode;
  logic [CHANNELS-1:0]   mask;
  logic [CHANNELS-1:0]   sel;
  logic [IDXW-1:0]       low_idx;

  always_comb begin
    state_d     = state_q;
    alive_d     = alive_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    winner_d    = winner_q;
    tie_d       = tie_q;
    low_idx     = '0;

    accept   = in_valid && (state_q == RUN || start);
    eff_mode = start ? mode : mode_q;
    mask     = start ? {CHANNELS{1'b1}} : alive_q;
    // Channels still matching the extreme value: those carrying the preferred bit.
    sel      = eff_mode ? (mask & ~din) : (mask & din);

    if (accept) begin
      out_valid_d = 1'b1;
      if (start) begin
        mode_d = mode;
      end
      // A channel is only dropped if someone else survives, so alive never empties.
      if (sel != '0) begin
        out_d   = ~eff_mode;
        alive_d = sel;
      end else begin
        out_d   = eff_mode;
        alive_d = mask;
      end

      if (start) begin
        cnt_d   = CW'(1);
        state_d = RUN;
      end else if (cnt_q == LAST) begin
        for (int i = CHANNELS - 1; i >= 0; i--) begin
          if (alive_d[i]) low_idx = IDXW'(i);
        end
        done_d   = 1'b1;
        winner_d = low_idx;
        tie_d    = (alive_d & (alive_d - 1'b1)) != '0;
        cnt_d    = '0;
        state_d  = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      alive_q     <= {CHANNELS{1'b1}};
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      winner_q    <= '0;
      tie_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      alive_q     <= alive_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      winner_q    <= winner_d;
      tie_q       <= tie_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign winner    = winner_q;
  assign tie       = tie_q;
  assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_serial_maxmin.sv
// Scoreboard bench for serial_maxmin: the driver predicts each output bit from
// per-channel prefix values, a negedge monitor pops and compares.
module tb_serial_maxmin;

  localparam int CH   = 4;
  localparam int W    = 8;
  localparam int IDXW = $clog2(CH);

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, start, mode;
  logic [CH-1:0]   din;
  logic            out, out_valid, done, tie, busy;
  logic [IDXW-1:0] winner;

  serial_maxmin #(.CHANNELS(CH), .WORD(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .start(start), .mode(mode),
    .din(din), .out(out), .out_valid(out_valid), .done(done),
    .winner(winner), .tie(tie), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            out;
    logic            done;
    logic            busy;
    logic [IDXW-1:0] winner;
    logic            tie;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model: each channel's word-so-far as an integer; the selected
  // stream is the low bit of the max (or min) prefix.
  bit              m_active = 0;
  bit              m_mode   = 0;
  int              m_cnt    = 0;
  logic [63:0]     m_pref[CH];
  logic [IDXW-1:0] m_winner = '0;
  bit              m_tie    = 0;

  task automatic model_accept(input bit s, input bit md, input logic [CH-1:0] d);
    logic [63:0] best;
    exp_t        it;
    int          n;
    if (s) begin
      m_active = 1;
      m_mode   = md;
      m_cnt    = 0;
      for (int i = 0; i < CH; i++) m_pref[i] = 0;
    end
    for (int i = 0; i < CH; i++) m_pref[i] = (m_pref[i] << 1) | 64'(d[i]);
    m_cnt++;
    best = m_pref[0];
    for (int i = 1; i < CH; i++)
      if (m_mode ? (m_pref[i] < best) : (m_pref[i] > best)) best = m_pref[i];
    it.out  = best[0];
    it.done = 1'b0;
    if (m_cnt == W) begin
      it.done = 1'b1;
      n = 0;
      for (int i = 0; i < CH; i++) begin
        if (m_pref[i] == best) begin
          if (n == 0) m_winner = IDXW'(i);
          n++;
        end
      end
      m_tie    = (n > 1);
      m_active = 0;
      m_cnt    = 0;
    end
    it.busy   = m_active;
    it.winner = m_winner;
    it.tie    = m_tie;
    sb.push_back(it);
  endtask

  task automatic drive(input bit v, input bit s, input bit md, input logic [CH-1:0] d);
    in_valid = v;
    start    = s;
    mode     = md;
    din      = d;
    if (v && (m_active || s)) model_accept(s, md, d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, '0);
  endtask

  // Monitor
  logic [63:0] obs_word = '0;
  int          done_cyc = 0;
  int          done_cnt = 0;
  exp_t        mon_it;

  always @(negedge clk) begin
    if (reset) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          mon_it = sb.pop_front();
          chk("out", 64'(out), 64'(mon_it.out));
          chk("done", 64'(done), 64'(mon_it.done));
          chk("busy", 64'(busy), 64'(mon_it.busy));
          chk("winner", 64'(winner), 64'(mon_it.winner));
          chk("tie", 64'(tie), 64'(mon_it.tie));
          obs_word = {obs_word[62:0], out};
          if (done) begin
            done_cyc = cyc;
            done_cnt++;
          end
        end
      end else if (done) begin
        chk("done_without_valid", 64'(done), 64'd0);
      end
    end
  end

  int start_cyc = 0;

  task automatic run_frame(input bit md, input logic [CH-1:0][W-1:0] w, input int nbits,
                           input int stall_at, input int stall_len);
    logic [CH-1:0] d;
    for (int k = 0; k < nbits; k++) begin
      if (k == stall_at) begin
        repeat (stall_len) drive(0, 1'($urandom), md, CH'($urandom));
      end
      for (int i = 0; i < CH; i++) d[i] = w[i][W-1-k];
      if (k == 0) start_cyc = cyc;
      drive(1, k == 0, md, d);
    end
  endtask

  task automatic check_frame(input string nm, input logic [W-1:0] exp_word,
                             input logic [IDXW-1:0] exp_win, input bit exp_tie, input int exp_lat);
    chk({nm, "_word"}, 64'(obs_word[W-1:0]), 64'(exp_word));
    chk({nm, "_winner"}, 64'(winner), 64'(exp_win));
    chk({nm, "_tie"}, 64'(tie), 64'(exp_tie));
    chk({nm, "_latency"}, 64'(done_cyc - start_cyc), 64'(exp_lat));
    $display("frame %s: word=%0h winner=%0d tie=%0d latency=%0d", nm, obs_word[W-1:0],
             winner, tie, done_cyc - start_cyc);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_out"}, 64'(out), 64'd0);
    chk({nm, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_winner"}, 64'(winner), 64'd0);
    chk({nm, "_tie"}, 64'(tie), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [CH-1:0][W-1:0] t1, t3, t5;
  int                   dc0;
  bit                   v, s;

  initial begin
    t1 = {8'h07, 8'hB7, 8'hB5, 8'h35};
    t3 = {8'h00, 8'hB7, 8'hB7, 8'h00};
    t5 = {8'h00, 8'h00, 8'h00, 8'hFF};
    reset = 1'b0; in_valid = 0; start = 0; mode = 0; din = '0;
    #3;
    check_reset_outputs("reset_init");
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;

    run_frame(0, t1, W, -1, 0); idle(2);
    check_frame("max", 8'hB7, 2'd2, 0, W);

    run_frame(1, t1, W, -1, 0); idle(2);
    check_frame("min", 8'h07, 2'd3, 0, W);

    run_frame(0, t3, W, -1, 0); idle(2);
    check_frame("tie", 8'hB7, 2'd1, 1, W);

    run_frame(0, t1, W, 4, 3); idle(2);
    check_frame("stall", 8'hB7, 2'd2, 0, W + 3);

    dc0 = done_cnt;
    run_frame(0, t1, 4, -1, 0);
    run_frame(0, t5, W, -1, 0); idle(2);
    check_frame("restart", 8'hFF, 2'd0, 0, W);
    chk("restart_done_count", 64'(done_cnt - dc0), 64'd1);

    // Back-to-back frames with no gap.
    run_frame(1, t1, W, -1, 0);
    run_frame(0, t3, W, -1, 0); idle(2);
    check_frame("b2b", 8'hB7, 2'd1, 1, W);

    // Asynchronous reset mid-frame, between clock edges.
    run_frame(0, t1, 3, -1, 0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    sb.delete();
    m_active = 0; m_winner = '0; m_tie = 0;
    in_valid = 0; start = 0;
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    drive(1, 0, 0, '1);
    idle(1);
    chk("post_reset_busy", 64'(busy), 64'd0);
    run_frame(0, t1, W, -1, 0); idle(2);
    check_frame("post_reset", 8'hB7, 2'd2, 0, W);

    // Randomized traffic: stalls, restarts, ignored start/valid combinations.
    for (int c = 0; c < 4000; c++) begin
      v = ($urandom % 4) != 0;
      s = m_active ? (($urandom % 40) == 0) : (($urandom % 3) == 0);
      drive(v, s, 1'($urandom), CH'($urandom));
    end
    idle(4);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_maxmin.md
# serial_maxmin

Bit-serial, MSB-first N-channel maximum/minimum selector. It extends the two-input serial comparator FSM to `CHANNELS` inputs and adds a max/min mode, input stall, frame restart, and winner-index/tie reporting. It sits on the serial datapath, where it consumes one bit per channel per accepted cycle and emits the selected word as a bit stream together with the identity of the winning channel.

## Interface
- `CHANNELS`, 4: number of serial input channels, 2..16.
- `WORD`, 8: bits per frame, 2..64.
- `IDXW`, `$clog2(CHANNELS)`: derived width of `winner`; not overridden.

- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset. Low clears all state immediately; release is synchronous to `clk`.
- `in_valid` input 1: `din` carries one valid bit per channel this cycle.
- `start` input 1: qualified by `in_valid`; marks the MSB of a new frame.
- `mode` input 1: 0 selects maximum, 1 selects minimum. Sampled with `start` and held for the frame.
- `din` input `CHANNELS`: current bit of each channel; bit i belongs to channel i.
- `out` output 1: selected bit, registered.
- `out_valid` output 1: `out` is valid this cycle.
- `done` output 1: one-cycle pulse coincident with the last bit of the frame.
- `winner` output `IDXW`: lowest-index surviving channel of the last completed frame.
- `tie` output 1: more than one channel survived the last completed frame.
- `busy` output 1: a frame is in progress (state RUN).

## Operation
- States:
  - IDLE: no frame in progress.
  - RUN: a frame is in progress. Internal state is the `alive[CHANNELS-1:0]` mask, the latched mode, and the bit counter `cnt` (0..WORD-1).
- Accept: an accept occurs on a rising edge when `in_valid`=1 and either state is RUN or `start`=1.
- `start`=1 with `in_valid`=0 is ignored in every state.
- `in_valid`=0 in RUN stalls the frame. `alive`, `cnt` and mode hold, and `out_valid`=0.
- Accept with `start`=1 (from IDLE or RUN):
  - Effective mask is all-ones; any frame in progress is abandoned with no `done`.
  - Latch `mode`.
  - The current `din` is processed as bit WORD-1.
  - `cnt` becomes 1 and state goes to RUN.
- Per accepted bit, with effective mask M (all-ones on start, else `alive`):
  - Max mode: S = M & din. If S≠0, out←1 and alive←S; else out←0 and alive←M.
  - Min mode: S = M & ~din. If S≠0, out←0 and alive←S; else out←1 and alive←M.
- The `alive` mask never becomes zero; channels are only removed when at least one channel survives.
- Last bit (accept with `cnt`=WORD-1 and `start`=0):
  - `done`←1.
  - `winner`←lowest set index of the new `alive`.
  - `tie`←(popcount(new `alive`) > 1).
  - State returns to IDLE and `cnt`←0.
- When `WORD`=... frames are always at least 2 bits, so `start` alone never completes a frame.
- `winner` and `tie` hold until the next `done`; they are not cleared by `start`.
- Values are unsigned; there is no sign handling.

## Timing
- Latency: `out` and `out_valid` are registered; they are valid in the cycle after the edge that accepts the bit (1-cycle latency).
- Throughput: one bit per channel per cycle when `in_valid` is continuous; a frame takes WORD cycles.
- `done` asserts in the same cycle as the final `out_valid`, for exactly one cycle. `winner` and `tie` update on the same edge.
- `busy` goes high on the edge that accepts `start` and goes low on the edge that accepts the last bit.
- A back-to-back `start` on the cycle after the last bit is accepted. There are no dead cycles between frames.
- A `start` accepted on the same edge that would have been the last bit restarts the frame; no `done` is issued for the old frame.
- Reset values (while `reset`=0, taking effect without waiting for `clk`):
  - `out`=0, `out_valid`=0, `done`=0, `busy`=0, `winner`=0, `tie`=0.
  - State IDLE, `alive`=all-ones, `cnt`=0.
- Reset mid-frame discards the frame. The first accept after release requires `start`.

## Test plan
- Max, CHANNELS=4, WORD=8, continuous valid. Inputs ch0=0x35, ch1=0xB5, ch2=0xB7, ch3=0x07. Required: `out` stream is 0xB7 MSB-first; `done` coincides with the 8th `out_valid`; `winner`=2; `tie`=0.
- Min, same inputs. Required: stream 0x07, `winner`=3, `tie`=0.
- Tie in max mode, ch1=ch2=0xB7, others 0x00. Required: stream 0xB7, `winner`=1, `tie`=1.
- Stall: same as the first test, with `in_valid` low for 3 cycles after bit 4. Required: `out_valid` gap of 3 cycles; `done` 3 cycles later than in the first test; identical stream and `winner`.
- Restart: `start` asserted again at the 5th bit with new data ch0=0xFF, others 0x00. Required: no `done` for the first frame; the second frame yields stream 0xFF, `winner`=0.
- Async reset: `reset` low mid-frame without a clock edge. Required: all outputs reach their reset values immediately. A following complete frame from the first test then produces correct results.
